// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: op codes, flag bit positions
// and the issue FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MAC = 4'b0100;
    localparam logic [3:0] OP_CLR = 4'b1111;

    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_OVF   = 1;
    localparam int unsigned FLAG_ZERO  = 2;
    localparam int unsigned FLAG_NEG   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_issue_unit.sv
// Sequential issue/capture front end for the external combinational ALU, owning the MAC accumulator.
// Optional macro ALU_ISSUE_STICKY_OVF_EN adds a sticky overflow output cleared by CLR or reset.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter logic [3:0]  MAC_OP = OP_MAC,
    parameter logic [3:0]  CLR_OP = OP_CLR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_acc,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
`ifdef ALU_ISSUE_STICKY_OVF_EN
    output logic             sticky_ovf,
`endif
    output logic [WIDTH-1:0] acc_value
);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [3:0]         alu_flags;
    logic               cmd_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_accept) state_d = (cmd_op == CLR_OP) ? RESP : EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by rst_n so nothing is offered while reset is asserted.
    always_comb begin
        cmd_ready = (state_q == IDLE) && rst_n;
        rsp_valid = (state_q == RESP);
    end

    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        alu_flags             = '0;
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_OVF]   = alu_overflow;
        alu_flags[FLAG_ZERO]  = alu_zero;
        alu_flags[FLAG_NEG]   = alu_negative;
    end

    // CLR leaves the operand registers alone so the ALU inputs never see the local op.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_op == CLR_OP) begin
                        acc_d              = '0;
                        result_d           = '0;
                        flags_d            = '0;
                        flags_d[FLAG_ZERO] = 1'b1;
                    end else begin
                        op_d = cmd_op;
                        a_d  = cmd_a;
                        b_d  = cmd_b;
                    end
                end
            end
            EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                if (op_q == MAC_OP) acc_d = alu_result;
            end
            default: ;
        endcase
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (state_q == IDLE && cmd_accept && cmd_op == CLR_OP) begin
            sticky_q <= 1'b0;
        end else if (state_q == EXEC && alu_overflow) begin
            sticky_q <= 1'b1;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = op_q;
    assign alu_acc    = acc_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign acc_value  = acc_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed testbench for alu_issue_unit with a behavioural ALU model on the ALU-facing ports.
// Define ALU_ISSUE_STICKY_OVF_EN for both bench and RTL to exercise the sticky overflow output.
module tb_alu_issue_unit;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_acc;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_zero;
   logic        alu_negative;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [31:0] acc_value;
`ifdef ALU_ISSUE_STICKY_OVF_EN
   logic        sticky_ovf;
`endif

   int testsRun;
   int failCount;
   logic [32:0] aluWide;

   alu_issue_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_a(cmd_a),
      .cmd_b(cmd_b),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_acc(alu_acc),
      .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .alu_carry(alu_carry),
      .alu_overflow(alu_overflow),
      .alu_zero(alu_zero),
      .alu_negative(alu_negative),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_result(rsp_result),
      .rsp_flags(rsp_flags),
`ifdef ALU_ISSUE_STICKY_OVF_EN
      .sticky_ovf(sticky_ovf),
`endif
      .acc_value(acc_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in ALU: add/sub produce carry and signed overflow, MAC is a*b+acc, unlisted ops return a^b.
   always_comb begin
      aluWide      = '0;
      alu_result   = '0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_ctrl)
         4'b0000: begin
            aluWide      = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result   = aluWide[31:0];
            alu_carry    = aluWide[32];
            alu_overflow = (alu_a[31] == alu_b[31]) && (aluWide[31] != alu_a[31]);
         end
         4'b0001: begin
            aluWide      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            alu_result   = aluWide[31:0];
            alu_carry    = aluWide[32];
            alu_overflow = (alu_a[31] != alu_b[31]) && (aluWide[31] != alu_a[31]);
         end
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a * alu_b + alu_acc;
         default: alu_result = alu_a ^ alu_b;
      endcase
   end

   assign alu_zero     = (alu_result == 32'd0);
   assign alu_negative = alu_result[31];

   // Watchdog so a stuck design still ends the run with a visible failure.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Presents one command in IDLE and returns at the falling edge of the cycle after acceptance.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      checkOutput("cmd_ready before accept", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Full ALU transaction with rsp_ready already high.
   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expAluAcc, input logic [31:0] expResult,
                        input logic [3:0] expFlags, input logic [31:0] expAcc);
      applyStimulus(op, a, b);
      checkOutput({tag, " exec rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, " exec alu_a"}, alu_a, a);
      checkOutput({tag, " exec alu_b"}, alu_b, b);
      checkOutput({tag, " exec alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, op});
      checkOutput({tag, " exec alu_acc"}, alu_acc, expAluAcc);
      @(negedge clk);
      checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      checkOutput({tag, " rsp_result"}, rsp_result, expResult);
      checkOutput({tag, " rsp_flags"}, {28'd0, rsp_flags}, {28'd0, expFlags});
      checkOutput({tag, " resp cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
      checkOutput({tag, " acc_value"}, acc_value, expAcc);
      @(negedge clk);
      checkOutput({tag, " done rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, " done cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   // Local clear: response one cycle after acceptance, zero flag only.
   task automatic runClear(input string tag, input logic [3:0] expCtrl);
      applyStimulus(OP_CLR, 32'hDEAD_BEEF, 32'h1234_5678);
      checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      checkOutput({tag, " rsp_result"}, rsp_result, 32'd0);
      checkOutput({tag, " rsp_flags"}, {28'd0, rsp_flags}, 32'h4);
      checkOutput({tag, " acc_value"}, acc_value, 32'd0);
      checkOutput({tag, " alu_ctrl held"}, {28'd0, alu_ctrl}, {28'd0, expCtrl});
      @(negedge clk);
      checkOutput({tag, " done rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      testsRun  = 0;
      failCount = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_a     = 32'd0;
      cmd_b     = 32'd0;
      rsp_ready = 1'b1;

      @(negedge clk);
      checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset rsp_result", rsp_result, 32'd0);
      checkOutput("reset rsp_flags", {28'd0, rsp_flags}, 32'd0);
      checkOutput("reset acc_value", acc_value, 32'd0);
      checkOutput("reset alu_a", alu_a, 32'd0);
      checkOutput("reset alu_b", alu_b, 32'd0);
      checkOutput("reset alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
`ifdef ALU_ISSUE_STICKY_OVF_EN
      checkOutput("reset sticky_ovf", {31'd0, sticky_ovf}, 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);

      runOp("add", OP_ADD, 32'd15, 32'd10, 32'd0, 32'd25, 4'b0000, 32'd0);
      runOp("sub", OP_SUB, 32'd20, 32'd15, 32'd0, 32'd5, 4'b0001, 32'd0);
      runOp("sub zero", OP_SUB, 32'd15, 32'd15, 32'd0, 32'd0, 4'b0101, 32'd0);

      runClear("clr", OP_SUB);
      runOp("mac1", OP_MAC, 32'd5, 32'd3, 32'd0, 32'd15, 4'b0000, 32'd15);
      runOp("mac2", OP_MAC, 32'd5, 32'd3, 32'd15, 32'd30, 4'b0000, 32'd30);

      // Back-pressure: response held while a competing command waits on the input.
      rsp_ready = 1'b0;
      applyStimulus(OP_OR, 32'hAAAA_AAAA, 32'h5555_5555);
      checkOutput("or exec alu_ctrl", {28'd0, alu_ctrl}, 32'h3);
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_a     = 32'd7;
      cmd_b     = 32'd7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("or hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("or hold rsp_result", rsp_result, 32'hFFFF_FFFF);
         checkOutput("or hold rsp_flags", {28'd0, rsp_flags}, 32'h8);
         checkOutput("or hold cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("or done rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("or done cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("or operands held", alu_a, 32'hAAAA_AAAA);
      checkOutput("or ctrl not overwritten", {28'd0, alu_ctrl}, 32'h3);
      checkOutput("or acc untouched", acc_value, 32'd30);

      runOp("fwd op5", 4'b0101, 32'h0000_00F0, 32'h0000_000F, 32'd30, 32'h0000_00FF, 4'b0000, 32'd30);

      // Reset pulse during EXEC aborts the MAC without a response.
      applyStimulus(OP_MAC, 32'd5, 32'd3);
      checkOutput("abort exec alu_ctrl", {28'd0, alu_ctrl}, 32'h4);
      rst_n = 1'b0;
      #1;
      checkOutput("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("abort acc_value", acc_value, 32'd0);
      checkOutput("abort cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("abort alu_a", alu_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort held rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      checkOutput("abort after rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("abort after cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("abort after acc_value", acc_value, 32'd0);

`ifdef ALU_ISSUE_STICKY_OVF_EN
      runOp("ovf add", OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 4'b1010, 32'd0);
      checkOutput("sticky set", {31'd0, sticky_ovf}, 32'd1);
      runOp("post ovf add", OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 4'b0000, 32'd0);
      checkOutput("sticky persists", {31'd0, sticky_ovf}, 32'd1);
      runClear("sticky clr", OP_ADD);
      checkOutput("sticky cleared", {31'd0, sticky_ovf}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
